// File: rtl/mux_pkg.sv
// mux_pkg: shared constants for the 4:1 lane multiplexer.
//   NUM_LANES - number of data lanes (4)
//   SEL_W     - width of the lane selector (2)
//   sel_e     - selector encodings SEL_L0..SEL_L3
package mux_pkg;

   localparam int NUM_LANES = 4;
   localparam int SEL_W     = 2;

   typedef enum logic [SEL_W-1:0] {
      SEL_L0 = 2'b00,
      SEL_L1 = 2'b01,
      SEL_L2 = 2'b10,
      SEL_L3 = 2'b11
   } sel_e;

endpackage

// File: rtl/mux_4to1_sel.sv
// mux_4to1_sel: purely combinational lane select.
//   in     [NUM_LANES*WIDTH] - packed lanes, lane k at bits [k*WIDTH +: WIDTH]
//   select [SEL_W]           - lane selector
//   out    [WIDTH]           - selected lane
module mux_4to1_sel
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [NUM_LANES*WIDTH-1:0] in,
   input  logic [SEL_W-1:0]           select,
   output logic [WIDTH-1:0]           out
);

   always_comb
      out = (select == SEL_L0) ? in[0*WIDTH +: WIDTH] :
            (select == SEL_L1) ? in[1*WIDTH +: WIDTH] :
            (select == SEL_L2) ? in[2*WIDTH +: WIDTH] :
                                 in[3*WIDTH +: WIDTH];

endmodule

// File: rtl/mux_4to1.sv
// mux_4to1: 4:1 lane multiplexer with an optional registered output stage.
//   in        [4*WIDTH] - packed lanes, lane k at bits [k*WIDTH +: WIDTH]
//   select    [2]       - lane selector
//   out       [WIDTH]   - combinational selected lane (never reset)
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid            - qualifies in/select for capture
//   out_q     [WIDTH]   - registered selected lane
//   out_valid           - qualifies out_q
//   sel_q     [2]       - select captured alongside out_q
// Macro MUX_4TO1_REG_OUT_EN compiles in the registered path; without it the
// "registered" outputs are plain wires mirroring out/select/in_valid.
module mux_4to1
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [NUM_LANES*WIDTH-1:0] in,
   input  logic [SEL_W-1:0]           select,
   output logic [WIDTH-1:0]           out,
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic [WIDTH-1:0]           out_q,
   output logic                       out_valid,
   output logic [SEL_W-1:0]           sel_q
);

   mux_4to1_sel #(.WIDTH(WIDTH)) u_sel (
      .in     (in),
      .select (select),
      .out    (out)
   );

`ifdef MUX_4TO1_REG_OUT_EN
   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] sel_reg_q, sel_reg_d;
   logic             valid_q, valid_d;

   // Data and select hold when idle; valid is a one-cycle strobe.
   always_comb begin
      data_d    = in_valid ? out : data_q;
      sel_reg_d = in_valid ? select : sel_reg_q;
      valid_d   = in_valid;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         data_q    <= '0;
         sel_reg_q <= SEL_L0;
         valid_q   <= 1'b0;
      end else begin
         data_q    <= data_d;
         sel_reg_q <= sel_reg_d;
         valid_q   <= valid_d;
      end

   assign out_q     = data_q;
   assign sel_q     = sel_reg_q;
   assign out_valid = valid_q;
`else
   // clk/rst_n are intentionally unused in the flop-free build.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;

   assign out_q     = out;
   assign sel_q     = select;
   assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: randomized self-checking bench for mux_4to1 (WIDTH=1 and WIDTH=8).
module tb_mux_4to1;

   logic        clk = 1'b0, rst_n = 1'b0, vld = 1'b0;
   logic [3:0]  in1 = '0;
   logic [1:0]  sel1 = '0, sq1;
   logic        out1, oq1, ov1;
   logic [31:0] in8 = '0;
   logic [1:0]  sel8 = '0, sq8;
   logic [7:0]  out8, oq8;
   logic        ov8;
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   mux_4to1 #(.WIDTH(1)) u1 (
      .in(in1), .select(sel1), .out(out1), .clk(clk), .rst_n(rst_n),
      .in_valid(vld), .out_q(oq1), .out_valid(ov1), .sel_q(sq1)
   );

   mux_4to1 #(.WIDTH(8)) u8 (
      .in(in8), .select(sel8), .out(out8), .clk(clk), .rst_n(rst_n),
      .in_valid(vld), .out_q(oq8), .out_valid(ov8), .sel_q(sq8)
   );

   // Reference: lane s of a word with w-bit lanes, by shift-and-mask.
   function automatic logic [7:0] pick(logic [31:0] v, logic [1:0] s, int w);
      return 8'((v >> (w * int'(s))) & ((32'd1 << w) - 32'd1));
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
`ifdef MUX_4TO1_REG_OUT_EN
      logic [7:0] e_q8 = '0;
      logic       e_q1 = 1'b0, e_v = 1'b0;
      logic [1:0] e_s8 = '0, e_s1 = '0;
`endif
      // Combinational directed cases, applied while reset is held.
      in1 = 4'b0010; sel1 = 2'b01; #1 check("dir_0010_s1", 32'(out1), 32'd1);
      in1 = 4'b1010; sel1 = 2'b11; #1 check("dir_1010_s3", 32'(out1), 32'd1);
      in1 = 4'b1011; sel1 = 2'b10; #1 check("dir_1011_s2", 32'(out1), 32'd0);
      in1 = 4'b1110; sel1 = 2'b00; #1 check("dir_1110_s0", 32'(out1), 32'd0);
      in1 = 4'b1111; sel1 = 2'b00; in1 = 4'b0000; sel1 = 2'b11; in1 = 4'b0010; sel1 = 2'b01;
      #1 check("same_step", 32'(out1), 32'd1);
      in8 = 32'h44332211; sel8 = 2'b10; #1 check("w8_comb_rst", 32'(out8), 32'h33);
`ifdef MUX_4TO1_REG_OUT_EN
      check("rst_oq8", 32'(oq8), 32'd0);
      check("rst_sq8", 32'(sq8), 32'd0);
      check("rst_ov8", 32'(ov8), 32'd0);
      check("rst_ov1", 32'(ov1), 32'd0);
      @(negedge clk) rst_n = 1'b1; vld = 1'b1;
      @(posedge clk) #1;
      check("cap_oq8", 32'(oq8), 32'h33);
      check("cap_sq8", 32'(sq8), 32'd2);
      check("cap_ov8", 32'(ov8), 32'd1);
      vld = 1'b0; in8 = 32'hAABBCCDD; sel8 = 2'b00;
      @(posedge clk) #1;
      check("idle_ov8", 32'(ov8), 32'd0);
      check("idle_oq8", 32'(oq8), 32'h33);
      check("idle_sq8", 32'(sq8), 32'd2);
      e_q8 = 8'h33; e_s8 = 2'b10; e_q1 = oq1; e_s1 = sq1;
      // Random stream: a junk drive, then the value that must be captured.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         in8 = $urandom; sel8 = 2'($urandom); in1 = 4'($urandom); sel1 = 2'($urandom);
         vld = 1'($urandom);
         #1;
         in8 = $urandom; sel8 = 2'($urandom); in1 = 4'($urandom); sel1 = 2'($urandom);
         vld = ($urandom_range(0, 3) != 0);
         #1;
         check("rnd_out8", 32'(out8), 32'(pick(in8, sel8, 8)));
         check("rnd_out1", 32'(out1), 32'(pick(32'(in1), sel1, 1)));
         e_v = vld;
         if (vld) begin
            e_q8 = pick(in8, sel8, 8); e_s8 = sel8;
            e_q1 = pick(32'(in1), sel1, 1) != 8'd0; e_s1 = sel1;
         end
         @(posedge clk) #1;
         check("rnd_oq8", 32'(oq8), 32'(e_q8));
         check("rnd_sq8", 32'(sq8), 32'(e_s8));
         check("rnd_ov8", 32'(ov8), 32'(e_v));
         check("rnd_oq1", 32'(oq1), 32'(e_q1));
         check("rnd_sq1", 32'(sq1), 32'(e_s1));
         check("rnd_ov1", 32'(ov1), 32'(e_v));
      end
      // Async reset mid-cycle while out_valid is high.
      @(negedge clk) in8 = 32'h99887766; sel8 = 2'b11; vld = 1'b1;
      @(posedge clk) #1 check("pre_rst_ov8", 32'(ov8), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_oq8", 32'(oq8), 32'd0);
      check("arst_sq8", 32'(sq8), 32'd0);
      check("arst_ov8", 32'(ov8), 32'd0);
      check("arst_out8", 32'(out8), 32'h99);
      @(posedge clk) #1 check("rst_hold_ov8", 32'(ov8), 32'd0);
      check("rst_hold_oq8", 32'(oq8), 32'd0);
      @(negedge clk) rst_n = 1'b1; sel8 = 2'b01;
      @(posedge clk) #1;
      check("first_cap_oq8", 32'(oq8), 32'h77);
      check("first_cap_sq8", 32'(sq8), 32'd1);
      check("first_cap_ov8", 32'(ov8), 32'd1);
`else
      // Flop-free build: registered outputs mirror the combinational path.
      check("pt_rst_oq8", 32'(oq8), 32'h33);
      check("pt_rst_sq8", 32'(sq8), 32'd2);
      @(negedge clk) rst_n = 1'b1;
      for (int p = 0; p < 16; p++)
         for (int s = 0; s < 4; s++) begin
            in1 = 4'(p); sel1 = 2'(s); vld = 1'($urandom);
            #1;
            check("pt_out1", 32'(out1), 32'(pick(32'(p), 2'(s), 1)));
            check("pt_oq1", 32'(oq1), 32'(pick(32'(p), 2'(s), 1)));
            check("pt_sq1", 32'(sq1), 32'(s));
            check("pt_ov1", 32'(ov1), 32'(vld));
         end
      for (int i = 0; i < 100; i++) begin
         in8 = $urandom; sel8 = 2'($urandom); vld = 1'($urandom);
         if (i == 50) rst_n = 1'b0;
         #3;
         check("pt_out8", 32'(out8), 32'(pick(in8, sel8, 8)));
         check("pt_oq8", 32'(oq8), 32'(pick(in8, sel8, 8)));
         check("pt_sq8", 32'(sq8), 32'(sel8));
         check("pt_ov8", 32'(ov8), 32'(vld));
      end
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux_4to1.md
MUX_4TO1 -- requirements
Module: mux_4to1

Interface
REQ-001 Parameter WIDTH, default 1, bits per data lane; the SHALL be legal for any value >= 1.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in  input  4*WIDTH  four packed lanes; lane k SHALL occupy bits [k*WIDTH +: WIDTH].
REQ-005 select  input  2  lane selector.
REQ-006 out  output  WIDTH  combinational selected lane.
REQ-007 in_valid  input  1  qualifies in/select for capture.
REQ-008 out_q  output  WIDTH  registered selected lane.
REQ-009 out_valid  output  1  qualifies out_q.
REQ-010 sel_q  output  2  select value captured with out_q.
REQ-011 Port order SHALL be in, select, out, then clk, rst_n, in_valid, out_q, out_valid, sel_q, so that positional instantiation with (in, select, out) binds correctly.

Function
REQ-012 out SHALL equal lane[select]: select 00 gives lane 0, 01 gives lane 1, 10 gives lane 2, 11 gives lane 3.
REQ-013 out SHALL have zero latency and SHALL track in/select changes within the same time step, independent of clk and rst_n.
REQ-014 On a rising clk edge with in_valid=1, out_q SHALL load lane[select], sel_q SHALL load select, and out_valid SHALL be set to 1.
REQ-015 On a rising clk edge with in_valid=0, out_q and sel_q SHALL hold their values and out_valid SHALL be cleared to 0.
REQ-016 out_q SHALL equal the out value sampled at the capturing edge, giving one-cycle latency.
REQ-017 Back-to-back in_valid=1 cycles SHALL each produce a new out_q with no bubbles and no backpressure.
REQ-018 Multiple in/select changes between clock edges SHALL affect only out; only the value present at the edge SHALL be captured.

Reset
REQ-019 rst_n=0 SHALL immediately, without waiting for clk, force out_q=0, sel_q=2'b00 and out_valid=0.
REQ-020 Reset asserted mid-stream SHALL discard any pending capture.
REQ-021 The first capture after reset SHALL occur on the first rising edge with rst_n=1 and in_valid=1.
REQ-022 out SHALL remain combinational and unaffected by reset.

Configuration
REQ-023 When macro MUX_4TO1_REG_OUT_EN is defined, the registered path of REQ-014 to REQ-021 SHALL be compiled in.
REQ-024 When MUX_4TO1_REG_OUT_EN is not defined, no flops SHALL exist: out_q SHALL equal out, sel_q SHALL equal select, out_valid SHALL equal in_valid, and clk/rst_n SHALL be unused.

Structure
REQ-025 A shared package mux_pkg SHALL hold the lane-count constant (4), the select width (2) and the select encodings SEL_L0 through SEL_L3.
REQ-026 The combinational lane select SHALL be a sub-module mux_4to1_sel (in, select -> out), instantiated once; registers SHALL live in mux_4to1.

Verification
REQ-027 WIDTH=1: in=0010, select=01 -> out=1; in=1010, select=11 -> out=1.
REQ-028 WIDTH=1: in=1011, select=10 -> out=0; in=1110, select=00 -> out=0.
REQ-029 Same-time-step re-drives of in/select with no delay between them -> out reflects only the final value (in=0010, select=01 -> out=1).
REQ-030 Macro defined, WIDTH=8, in=0x44332211, select=10, in_valid=1 for one edge -> next cycle out_q=0x33, sel_q=10, out_valid=1; following idle edge -> out_valid=0 and out_q holds 0x33.
REQ-031 Macro defined, rst_n pulled low between edges while out_valid=1 -> out_q=0, sel_q=00, out_valid=0 immediately, with out still combinational.
REQ-032 Macro undefined -> out_q tracks out and out_valid tracks in_valid with zero latency for all 16 in patterns crossed with all 4 select values.
